dac_sin_spi_tx: RTL and testbench

//  Downstream stage of the rectified-sine generator. Takes the sign S and the scaled

---
 rtl/dac_sin_spi_tx.sv | 189 ++++++++++++++++++
 tb/tb_dac_sin_spi_tx.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_sin_spi_tx.sv
// dac_sin_spi_tx
// Rebuilds an offset-binary DAC code from sign + magnitude on each ce strobe and
// ships it to a 12-bit SPI DAC as a 16-bit frame {CTRL, code}, MSB first.
// A frame is LOAD (DIV) + 16 bits x (2*DIV) + HOLD (DIV) = 34*DIV clk cycles.
// Samples that arrive while a frame is in flight are dropped and flagged in ovf.
// frm_co marks the end of a frame whose sample carried the period-start flag.
module dac_sin_spi_tx #(
   parameter int         SH   = 2048,
   parameter int         DIV  = 2,
   parameter logic [3:0] CTRL = 4'b0011
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ce,
   input  logic        S,
   input  logic [11:0] Mmod_SIN,
   input  logic        CO_SIN,
   output logic        SCLK,
   output logic        CS_n,
   output logic        SDO,
   output logic        busy,
   output logic [11:0] code,
   output logic        ovf,
   output logic        frm_co
);

   localparam int              DW       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DW-1:0]   DIV_LAST = DW'(DIV - 1);
   localparam logic [11:0]     SH_CODE  = 12'(SH);
   // One bit wider than a bare 13-bit sum so SH + 4095 cannot wrap before saturation.
   localparam logic signed [13:0] SH_S  = 14'(SH);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, HOLD} state_t;

   state_t         state_reg,   state_next;
   logic [DW-1:0]  div_cnt_reg, div_cnt_next;
   logic [3:0]     bit_cnt_reg, bit_cnt_next;
   logic           sclk_hi_reg, sclk_hi_next;
   logic [15:0]    shreg_reg,   shreg_next;
   logic           co_flag_reg, co_flag_next;
   logic [11:0]    code_reg,    code_next;
   logic           sclk_reg,    sclk_next;
   logic           cs_n_reg,    cs_n_next;
   logic           sdo_reg,     sdo_next;
   logic           busy_reg,    busy_next;
   logic           ovf_reg,     ovf_next;
   logic           frm_co_reg,  frm_co_next;

   logic signed [13:0] mag_s;
   logic signed [13:0] sum;
   logic [11:0]        code_sat;

   // Signed reconstruction around mid-scale with clamp to the 12-bit DAC range
   always_comb begin
      mag_s = signed'({2'b00, Mmod_SIN});
      sum   = S ? (SH_S + mag_s) : (SH_S - mag_s);
      if (sum < 14'sd0)
         code_sat = 12'd0;
      else if (sum > 14'sd4095)
         code_sat = 12'hFFF;
      else
         code_sat = sum[11:0];
   end

   // Next-state and next-output logic; every output is registered from these
   always_comb begin
      state_next   = state_reg;
      div_cnt_next = div_cnt_reg;
      bit_cnt_next = bit_cnt_reg;
      sclk_hi_next = sclk_hi_reg;
      shreg_next   = shreg_reg;
      co_flag_next = co_flag_reg;
      code_next    = code_reg;
      sclk_next    = sclk_reg;
      cs_n_next    = cs_n_reg;
      sdo_next     = sdo_reg;
      busy_next    = busy_reg;
      ovf_next     = ovf_reg | (ce && (state_reg != IDLE));
      frm_co_next  = 1'b0;

      case (state_reg)
         IDLE: begin
            if (ce) begin
               state_next   = LOAD;
               div_cnt_next = '0;
               code_next    = code_sat;
               shreg_next   = {CTRL, code_sat};
               co_flag_next = CO_SIN;
               cs_n_next    = 1'b0;
               sclk_next    = 1'b0;
               sdo_next     = CTRL[3];
               busy_next    = 1'b1;
            end
         end
         LOAD: begin
            if (div_cnt_reg == DIV_LAST) begin
               state_next   = SHIFT;
               div_cnt_next = '0;
               bit_cnt_next = 4'd15;
               sclk_hi_next = 1'b0;
            end else begin
               div_cnt_next = div_cnt_reg + DW'(1);
            end
         end
         SHIFT: begin
            if (div_cnt_reg != DIV_LAST) begin
               div_cnt_next = div_cnt_reg + DW'(1);
            end else begin
               div_cnt_next = '0;
               if (!sclk_hi_reg) begin
                  sclk_hi_next = 1'b1;
                  sclk_next    = 1'b1;
               end else if (bit_cnt_reg == 4'd0) begin
                  state_next   = HOLD;
                  sclk_hi_next = 1'b0;
                  sclk_next    = 1'b0;
                  cs_n_next    = 1'b1;
                  sdo_next     = 1'b0;
               end else begin
                  // Falling SCLK: present the next bit in the same cycle
                  bit_cnt_next = bit_cnt_reg - 4'd1;
                  shreg_next   = {shreg_reg[14:0], 1'b0};
                  sdo_next     = shreg_reg[14];
                  sclk_hi_next = 1'b0;
                  sclk_next    = 1'b0;
               end
            end
         end
         HOLD: begin
            if (div_cnt_reg == DIV_LAST) begin
               state_next   = IDLE;
               div_cnt_next = '0;
               busy_next    = 1'b0;
            end else begin
               div_cnt_next = div_cnt_reg + DW'(1);
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // Pulse lines up with the final HOLD cycle
      if ((state_next == HOLD) && (div_cnt_next == DIV_LAST))
         frm_co_next = co_flag_reg;
   end

   // State, datapath and output registers; reset aborts any frame immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         div_cnt_reg <= '0;
         bit_cnt_reg <= '0;
         sclk_hi_reg <= 1'b0;
         shreg_reg   <= '0;
         co_flag_reg <= 1'b0;
         code_reg    <= SH_CODE;
         sclk_reg    <= 1'b0;
         cs_n_reg    <= 1'b1;
         sdo_reg     <= 1'b0;
         busy_reg    <= 1'b0;
         ovf_reg     <= 1'b0;
         frm_co_reg  <= 1'b0;
      end else begin
         state_reg   <= state_next;
         div_cnt_reg <= div_cnt_next;
         bit_cnt_reg <= bit_cnt_next;
         sclk_hi_reg <= sclk_hi_next;
         shreg_reg   <= shreg_next;
         co_flag_reg <= co_flag_next;
         code_reg    <= code_next;
         sclk_reg    <= sclk_next;
         cs_n_reg    <= cs_n_next;
         sdo_reg     <= sdo_next;
         busy_reg    <= busy_next;
         ovf_reg     <= ovf_next;
         frm_co_reg  <= frm_co_next;
      end
   end

   assign SCLK   = sclk_reg;
   assign CS_n   = cs_n_reg;
   assign SDO    = sdo_reg;
   assign busy   = busy_reg;
   assign code   = code_reg;
   assign ovf    = ovf_reg;
   assign frm_co = frm_co_reg;

endmodule

// File: tb/tb_dac_sin_spi_tx.sv
// Testbench for dac_sin_spi_tx: table vectors, corner-case sequences and a
// randomized run, all checked against an arithmetic model of the DAC frame.
`timescale 1ns/1ps
module tb_dac_sin_spi_tx;

   localparam int DIV      = 2;
   localparam int BUSY_CYC = 34 * DIV;
   localparam int CS_CYC   = 33 * DIV;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ce = 1'b0;
   logic        s_in = 1'b0;
   logic [11:0] mag = 12'd0;
   logic        co_sin = 1'b0;
   logic        sclk, cs_n, sdo, busy, ovf, frm_co;
   logic [11:0] code;

   dac_sin_spi_tx #(.SH(2048), .DIV(DIV), .CTRL(4'b0011)) dut (
      .clk(clk), .rst_n(rst_n), .ce(ce), .S(s_in), .Mmod_SIN(mag), .CO_SIN(co_sin),
      .SCLK(sclk), .CS_n(cs_n), .SDO(sdo), .busy(busy), .code(code), .ovf(ovf),
      .frm_co(frm_co)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Frame capture state, maintained by the monitor
   logic [15:0] sh_acc = '0, last_frame = '0;
   int rise_cnt = 0, cs_cnt = 0, busy_cnt = 0;
   int last_rises = 0, last_cs = 0, last_busy = 0;
   int frame_done = 0, busy_done = 0;
   int frm_co_cnt = 0, frm_co_pos = 0, frm_co_long = 0;
   int sdo_unstable = 0, sclk_idle = 0;
   logic prev_sclk = 0, prev_cs = 1, prev_busy = 0, prev_sdo = 0, prev_frm_co = 0;

   // Monitor: decode frames on SCLK rising, measure CS_n/busy widths and frm_co placement
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         sh_acc = '0; rise_cnt = 0; cs_cnt = 0; busy_cnt = 0;
         prev_sclk = 0; prev_cs = 1; prev_busy = 0; prev_sdo = 0; prev_frm_co = 0;
      end else begin
         if (sclk && !prev_sclk) begin
            sh_acc = {sh_acc[14:0], sdo};
            rise_cnt++;
         end
         if (sclk && prev_sclk && (sdo != prev_sdo)) sdo_unstable++;
         if (sclk && cs_n) sclk_idle++;
         if (!cs_n) cs_cnt++;
         if (busy) busy_cnt++;
         if (frm_co) begin
            frm_co_cnt++;
            frm_co_pos = busy_cnt;
            if (prev_frm_co) frm_co_long++;
         end
         if (cs_n && !prev_cs) begin
            last_frame = sh_acc; last_rises = rise_cnt; last_cs = cs_cnt;
            frame_done++;
            sh_acc = '0; rise_cnt = 0; cs_cnt = 0;
         end
         if (!busy && prev_busy) begin
            last_busy = busy_cnt;
            busy_done++;
            busy_cnt = 0;
         end
         prev_sclk = sclk; prev_cs = cs_n; prev_busy = busy; prev_sdo = sdo; prev_frm_co = frm_co;
      end
   end

   // Reference model: mid-scale plus signed magnitude, clamped to 0..4095
   function automatic logic [11:0] ref_code(input logic sg, input int m);
      int v;
      v = sg ? (2048 + m) : (2048 - m);
      if (v > 4095) v = 4095;
      if (v < 0) v = 0;
      return 12'(v);
   endfunction

   function automatic logic [15:0] ref_frame(input logic sg, input int m);
      return {4'b0011, ref_code(sg, m)};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Called just after a negedge; ce is seen by exactly one rising edge
   task automatic send(input logic sg, input int m, input logic co);
      ce = 1'b1; s_in = sg; mag = 12'(m); co_sin = co;
      @(negedge clk);
      ce = 1'b0; co_sin = 1'b0;
   endtask

   task automatic wait_busy(input int target, input string name);
      int cyc;
      cyc = 0;
      while (busy_done < target && cyc < 400) begin
         @(negedge clk); #1;
         cyc++;
      end
      chk({name, "_timeout"}, busy_done, target);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk); #1;
   endtask

   typedef struct {
      logic        sg;
      int          m;
      logic        co;
      logic [11:0] exp_code;
      logic [15:0] exp_frame;
   } vec_t;

   vec_t vecs[9];

   initial begin
      int start, fc0, n_co;
      logic [11:0] code_a;
      logic [15:0] frm_a;
      logic sg_r, co_r;
      int m_r;

      vecs[0] = '{1'b1, 1000, 1'b0, 12'hBE8, 16'h3BE8};
      vecs[1] = '{1'b0, 1000, 1'b0, 12'h418, 16'h3418};
      vecs[2] = '{1'b1, 2500, 1'b0, 12'hFFF, 16'h3FFF};
      vecs[3] = '{1'b0, 3000, 1'b0, 12'h000, 16'h3000};
      vecs[4] = '{1'b1,    0, 1'b1, 12'h800, 16'h3800};
      vecs[5] = '{1'b1, 2047, 1'b0, 12'hFFF, 16'h3FFF};
      vecs[6] = '{1'b1, 2048, 1'b1, 12'hFFF, 16'h3FFF};
      vecs[7] = '{1'b0, 2048, 1'b0, 12'h000, 16'h3000};
      vecs[8] = '{1'b0, 2049, 1'b0, 12'h000, 16'h3000};

      // Reset state
      repeat (2) @(negedge clk); #1;
      chk("rst_sclk", sclk, 0);   chk("rst_cs_n", cs_n, 1);  chk("rst_sdo", sdo, 0);
      chk("rst_busy", busy, 0);   chk("rst_code", code, 12'h800);
      chk("rst_ovf", ovf, 0);     chk("rst_frm_co", frm_co, 0);
      rst_n = 1'b1;
      @(negedge clk); #1;

      // Table-driven frames
      for (int i = 0; i < 9; i++) begin
         start = busy_done;
         fc0 = frm_co_cnt;
         send(vecs[i].sg, vecs[i].m, vecs[i].co);
         wait_busy(start + 1, "vec");
         $display("vec %0d: S=%0d M=%0d code=0x%03h frame=0x%04h", i, vecs[i].sg, vecs[i].m,
                  code, last_frame);
         chk("vec_code", code, vecs[i].exp_code);
         chk("vec_frame", last_frame, vecs[i].exp_frame);
         chk("vec_rises", last_rises, 16);
         chk("vec_cs_low", last_cs, CS_CYC);
         chk("vec_busy", last_busy, BUSY_CYC);
         chk("vec_frm_co_cnt", frm_co_cnt - fc0, int'(vecs[i].co));
         if (vecs[i].co) chk("vec_frm_co_pos", frm_co_pos, BUSY_CYC);
         chk("vec_ovf", ovf, 0);
      end

      // ce on the last HOLD cycle is dropped; ce one cycle later is accepted
      start = busy_done;
      ce = 1'b1; s_in = 1'b1; mag = 12'd100;
      @(negedge clk);
      ce = 1'b0;
      repeat (67) @(negedge clk);
      chk("hold_busy_last", busy, 1);
      ce = 1'b1; s_in = 1'b0; mag = 12'd200;
      @(negedge clk);
      chk("hold_busy_end", busy, 0);
      chk("hold_drop_ovf", ovf, 1);
      chk("hold_drop_code", code, ref_code(1'b1, 100));
      @(negedge clk);
      ce = 1'b0;
      chk("max_rate_busy", busy, 1);
      chk("max_rate_code", code, ref_code(1'b0, 200));
      wait_busy(start + 2, "max_rate");
      $display("max-rate: code=0x%03h frame=0x%04h", code, last_frame);
      chk("max_rate_frame", last_frame, ref_frame(1'b0, 200));

      // Overrun 10 cycles into a frame
      do_reset();
      chk("ovr_rst_ovf", ovf, 0);
      start = busy_done;
      send(1'b1, 300, 1'b0);
      repeat (9) @(negedge clk);
      send(1'b0, 900, 1'b0);
      wait_busy(start + 1, "ovr");
      $display("overrun: code=0x%03h frame=0x%04h ovf=%0d", code, last_frame, ovf);
      chk("ovr_frame", last_frame, ref_frame(1'b1, 300));
      chk("ovr_code", code, ref_code(1'b1, 300));
      chk("ovr_ovf", ovf, 1);
      send(1'b0, 5, 1'b0);
      wait_busy(start + 2, "ovr2");
      chk("ovr2_frame", last_frame, ref_frame(1'b0, 5));
      chk("ovr_sticky", ovf, 1);

      // Reset in the middle of bit 7
      do_reset();
      start = busy_done;
      code_a = ref_code(1'b0, 1234);
      send(1'b0, 1234, 1'b1);
      for (int c = 0; c < 200 && rise_cnt < 9; c++) begin
         @(negedge clk); #1;
      end
      chk("mid_rise_cnt", rise_cnt, 9);
      chk("mid_code", code, code_a);
      rst_n = 1'b0;
      #1;
      chk("mid_cs_n", cs_n, 1);  chk("mid_sclk", sclk, 0);
      chk("mid_busy", busy, 0);  chk("mid_code_rst", code, 12'h800);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk); #1;
      chk("mid_no_frame", busy_done, start);
      fc0 = frm_co_cnt;
      send(1'b1, 77, 1'b0);
      wait_busy(start + 1, "mid_after");
      $display("post-reset: code=0x%03h frame=0x%04h", code, last_frame);
      chk("mid_after_frame", last_frame, ref_frame(1'b1, 77));
      chk("mid_after_rises", last_rises, 16);
      chk("mid_after_frm_co", frm_co_cnt - fc0, 0);

      // Randomized samples at or below the maximum rate
      do_reset();
      fc0 = frm_co_cnt;
      n_co = 0;
      for (int i = 0; i < 40; i++) begin
         start = busy_done;
         sg_r = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0:       m_r = $urandom_range(2040, 2060);
            1:       m_r = $urandom_range(4000, 4095);
            default: m_r = $urandom_range(0, 4095);
         endcase
         co_r = (i % 10) == 0;
         if (co_r) n_co++;
         send(sg_r, m_r, co_r);
         wait_busy(start + 1, "rnd");
         $display("rnd %0d: S=%0d M=%0d frame=0x%04h", i, sg_r, m_r, last_frame);
         chk("rnd_frame", last_frame, ref_frame(sg_r, m_r));
         chk("rnd_code", code, ref_code(sg_r, m_r));
         repeat ($urandom_range(0, 4)) @(negedge clk);
         #1;
      end
      chk("rnd_ovf", ovf, 0);
      chk("rnd_frm_co", frm_co_cnt - fc0, n_co);
      chk("frm_co_width", frm_co_long, 0);
      chk("sdo_stable", sdo_unstable, 0);
      chk("sclk_idle", sclk_idle, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
